ov7670_capture: RTL

Captures the OV7670 camera's 8-bit RGB565 byte stream and writes 16-bit pixels into the 320x240 frame buffer. The display path reads that same buffer at `addr = row*320 + col` and scales each pixel 2x for the 640x480 VGA output. This block is the write-side producer for that shared address space. It runs on the camera pixel clock, frames on VSYNC/HREF, pairs bytes into pixels, decimates 640x480 input by 2, and generates sequential write addresses.

---
 rtl/ov7670_cap_pkg.sv | 22 ++
 rtl/ov7670_cap_if.sv | 23 ++
 rtl/ov7670_byte_pair.sv | 38 +++
 rtl/ov7670_capture.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ov7670_cap_pkg.sv
// Shared types and constants for the OV7670 capture path into the 320x240 frame buffer.
package ov7670_cap_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_VS  = 2'd1,
      WAIT_END = 2'd2,
      CAPTURE  = 2'd3
   } cap_state_t;

   localparam int CAM_W     = 640;
   localparam int CAM_H     = 480;
   localparam int FB_W      = 320;
   localparam int FB_H      = 240;
   localparam int FB_ADDR_W = 17;

   // Width of a counter that must be able to hold the value n itself.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ov7670_cap_if.sv
// Camera byte bus in, frame-buffer write bus out, seen from the capture block (master).
interface ov7670_cap_if
   import ov7670_cap_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W
) ();
   logic              cam_vsync;
   logic              cam_href;
   logic [7:0]        cam_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;

   modport master (
      input  cam_vsync, cam_href, cam_data,
      output wr_en, wr_addr, wr_data
   );

   modport slave (
      output cam_vsync, cam_href, cam_data,
      input  wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/ov7670_byte_pair.sv
// Pairs consecutive camera bytes into one RGB565 pixel; first byte lands in [15:8].
module ov7670_byte_pair (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        line_clr,
   input  logic [7:0]  data,
   output logic        phase,
   output logic        pix_valid,
   output logic [15:0] pixel
);

   logic [7:0] hi;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase     <= 1'b0;
         hi        <= 8'd0;
         pix_valid <= 1'b0;
         pixel     <= 16'd0;
      end else begin
         pix_valid <= 1'b0;
         if (line_clr) begin
            phase <= 1'b0;
         end else if (en) begin
            if (!phase) begin
               hi    <= data;
               phase <= 1'b1;
            end else begin
               pixel     <= {hi, data};
               pix_valid <= 1'b1;
               phase     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture: frames on VSYNC/HREF, pairs bytes, decimates and writes
// pixels to the frame buffer at sequential addresses.
//
// state    | meaning
// IDLE     | capture disabled, waiting for cap_en
// WAIT_VS  | enabled, waiting for VSYNC to rise (no partial frames)
// WAIT_END | in vertical blank, frame starts when VSYNC falls
// CAPTURE  | storing pixels until the next VSYNC rise
module ov7670_capture
   import ov7670_cap_pkg::*;
#(
   parameter int H_ACTIVE = CAM_W,
   parameter int V_ACTIVE = CAM_H,
   parameter int DECIM    = 2,
   parameter int ADDR_W   = FB_ADDR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cap_en,
   ov7670_cap_if.master bus,
   output logic         frame_done,
   output logic [7:0]   frame_cnt,
   output logic         line_err,
   output logic         ovf
);

   localparam int OUT_W = H_ACTIVE / DECIM;
   localparam int XW    = cnt_w(H_ACTIVE);
   localparam int YW    = cnt_w(V_ACTIVE);
   localparam logic [XW-1:0]     X_LIM    = XW'(H_ACTIVE);
   localparam logic [YW-1:0]     Y_LIM    = YW'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(OUT_W);

   cap_state_t        state;
   logic              vs_r, vs_d, hr_r, hr_d;
   logic [7:0]        d_r;
   logic              vs_rise_q, vs_fall_q, eol_q, odd_q;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] base;

   logic              hr_fall, frame_start, pair_en, line_clr;
   logic              bp_phase, pix_valid;
   logic [15:0]       pixel;
   logic              x_in, y_in, row_keep, pix_keep;
   logic [XW-1:0]     col;

   assign hr_fall     = hr_d && !hr_r;
   assign frame_start = (state == WAIT_END) && vs_fall_q;
   assign pair_en     = (state == CAPTURE) && hr_r && !vs_r;
   assign line_clr    = hr_fall || frame_start;

   assign x_in     = x < X_LIM;
   assign y_in     = y < Y_LIM;
   assign row_keep = y_in && ((DECIM == 1) || !y[0]);
   assign pix_keep = x_in && row_keep && ((DECIM == 1) || !x[0]);
   assign col      = (DECIM == 2) ? (x >> 1) : x;

   ov7670_byte_pair u_pair (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (pair_en),
      .line_clr  (line_clr),
      .data      (d_r),
      .phase     (bp_phase),
      .pix_valid (pix_valid),
      .pixel     (pixel)
   );

   // Sync edges are registered once more so line/frame events line up with the
   // pixel coming out of the byte pairer (two edges after the pins).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         vs_r        <= 1'b0;
         vs_d        <= 1'b0;
         hr_r        <= 1'b0;
         hr_d        <= 1'b0;
         d_r         <= 8'd0;
         vs_rise_q   <= 1'b0;
         vs_fall_q   <= 1'b0;
         eol_q       <= 1'b0;
         odd_q       <= 1'b0;
         x           <= '0;
         y           <= '0;
         base        <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= 16'd0;
         frame_done  <= 1'b0;
         frame_cnt   <= 8'd0;
         line_err    <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         vs_r      <= bus.cam_vsync;
         hr_r      <= bus.cam_href;
         d_r       <= bus.cam_data;
         vs_d      <= vs_r;
         hr_d      <= hr_r;
         vs_rise_q <= vs_r && !vs_d;
         vs_fall_q <= !vs_r && vs_d;
         eol_q     <= hr_fall && (state == CAPTURE);
         odd_q     <= hr_fall && (state == CAPTURE) && bp_phase;

         bus.wr_en  <= 1'b0;
         frame_done <= 1'b0;

         case (state)
            IDLE: begin
               if (cap_en) state <= WAIT_VS;
            end
            WAIT_VS: begin
               if (vs_rise_q) state <= WAIT_END;
            end
            WAIT_END: begin
               if (vs_fall_q) begin
                  state    <= CAPTURE;
                  x        <= '0;
                  y        <= '0;
                  base     <= '0;
                  line_err <= 1'b0;
                  ovf      <= 1'b0;
               end
            end
            CAPTURE: begin
               if (pix_valid) begin
                  if (pix_keep) begin
                     bus.wr_en   <= 1'b1;
                     bus.wr_addr <= base + ADDR_W'(col);
                     bus.wr_data <= pixel;
                  end else if (!x_in || !y_in) begin
                     ovf <= 1'b1;
                  end
                  if (x_in) x <= x + XW'(1);
               end
               // End of line comes before frame end when both land together.
               if (eol_q) begin
                  if (odd_q) line_err <= 1'b1;
                  x <= '0;
                  if (row_keep) base <= base + ROW_STEP;
                  if (y_in) y <= y + YW'(1);
               end
               if (vs_rise_q) begin
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 8'd1;
                  state      <= cap_en ? WAIT_END : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
